// File: rtl/pe_pkg.sv
// Shared PE definitions: operand/accumulator widths
// and the signed saturation bounds of the psum path.
package pe_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
    {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
    {1'b1, {(ACC_WIDTH-1){1'b0}}};
endpackage

// File: rtl/sat_adder.sv
// Signed W-bit adder that clamps to the representable
// range and flags when the clamp was applied.
module sat_adder
  import pe_pkg::*;
#(
  parameter int W = ACC_WIDTH
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);
  logic signed [W:0] ext;

  assign ext = {a[W-1], a} + {b[W-1], b};
  assign ovf = ext[W] ^ ext[W-1];

  always_comb begin
    sum = ext[W-1:0];
    if (ovf)
      sum = ext[W] ? {1'b1, {(W-1){1'b0}}}
                   : {1'b0, {(W-1){1'b1}}};
  end
endmodule

// File: rtl/mac_accumulator.sv
// Two-stage signed MAC: register the product, then
// accumulate with saturation and emit one psum per window.
module mac_accumulator #(
  parameter int DATA_WIDTH = pe_pkg::DATA_WIDTH,
  parameter int ACC_WIDTH  = pe_pkg::ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] ifmap_in,
  input  logic signed [DATA_WIDTH-1:0] filter_in,
  input  logic signed [ACC_WIDTH-1:0]  psum_in,
  input  logic                         first,
  input  logic                         last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_WIDTH-1:0]  acc_out,
  output logic                         sat_out
);
  localparam int XW = ACC_WIDTH - DATA_WIDTH;

  logic advance;
  logic accept;
  logic fire2;

  logic                        v1;
  logic                        first1;
  logic                        last1;
  logic signed [ACC_WIDTH-1:0] p1;
  logic signed [ACC_WIDTH-1:0] psum1;

  logic signed [ACC_WIDTH-1:0] acc;
  logic                        sat_acc;

  logic signed [ACC_WIDTH-1:0] xe;
  logic signed [ACC_WIDTH-1:0] we;
  logic signed [ACC_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0] base;
  logic signed [ACC_WIDTH-1:0] sum;
  logic                        hit;
  logic                        sat_next;

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;
  assign accept   = in_valid && advance;
  assign fire2    = advance && v1;

  assign xe = {{XW{ifmap_in[DATA_WIDTH-1]}}, ifmap_in};
  assign we = {{XW{filter_in[DATA_WIDTH-1]}}, filter_in};
  // Zero ifmap skips the multiplier toggle entirely
  assign prod = (ifmap_in == '0) ? '0 : xe * we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      first1 <= 1'b0;
      last1  <= 1'b0;
      p1     <= '0;
      psum1  <= '0;
    end else if (advance) begin
      v1 <= accept;
      if (accept) begin
        first1 <= first;
        last1  <= last;
        p1     <= prod;
        psum1  <= psum_in;
      end
    end
  end

  assign base     = first1 ? psum1 : acc;
  assign sat_next = (first1 ? 1'b0 : sat_acc) | hit;

  sat_adder #(.W(ACC_WIDTH)) u_add (
    .a   (base),
    .b   (p1),
    .sum (sum),
    .ovf (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      sat_acc <= 1'b0;
    end else if (fire2) begin
      acc     <= last1 ? '0 : sum;
      sat_acc <= last1 ? 1'b0 : sat_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      acc_out   <= '0;
      sat_out   <= 1'b0;
    end else if (fire2 && last1) begin
      out_valid <= 1'b1;
      acc_out   <= sum;
      sat_out   <= sat_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed + random bench for mac_accumulator with a
// reference model feeding a result scoreboard.
module tb_mac_accumulator;
  import pe_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] ifmap_in;
  logic signed [DW-1:0] filter_in;
  logic signed [AW-1:0] psum_in;
  logic                 first;
  logic                 last;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [AW-1:0] acc_out;
  logic                 sat_out;

  typedef struct packed {
    logic [AW-1:0] acc;
    logic          sat;
  } res_t;

  res_t sbq[$];
  int total = 0;
  int bad = 0;
  logic signed [AW-1:0] m_acc;
  logic                 m_sat;
  bit rand_rdy = 1'b0;

  always #5 clk = ~clk;

  mac_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ifmap_in  (ifmap_in),
    .filter_in (filter_in),
    .psum_in   (psum_in),
    .first     (first),
    .last      (last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .sat_out   (sat_out)
  );

  task automatic chk(input string tag,
                     input logic [AW-1:0] obs,
                     input logic [AW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic signed [DW-1:0] x,
                       input logic signed [DW-1:0] w,
                       input logic signed [AW-1:0] ps,
                       input logic f,
                       input logic l);
    logic signed [AW-1:0] xe, we, prod, base, c;
    logic signed [AW:0]   s;
    logic                 h;
    xe   = {{(AW-DW){x[DW-1]}}, x};
    we   = {{(AW-DW){w[DW-1]}}, w};
    prod = xe * we;
    base = f ? ps : m_acc;
    s    = {base[AW-1], base} + {prod[AW-1], prod};
    h    = 1'b1;
    if (s > ACC_MAX) c = ACC_MAX;
    else if (s < ACC_MIN) c = ACC_MIN;
    else begin
      c = s[AW-1:0];
      h = 1'b0;
    end
    m_sat = (f ? 1'b0 : m_sat) | h;
    if (l) begin
      sbq.push_back('{c, m_sat});
      m_acc = '0;
      m_sat = 1'b0;
    end else begin
      m_acc = c;
    end
  endtask

  task automatic send(input logic signed [DW-1:0] x,
                      input logic signed [DW-1:0] w,
                      input logic signed [AW-1:0] ps,
                      input logic f,
                      input logic l);
    int n;
    @(negedge clk);
    ifmap_in  = x;
    filter_in = w;
    psum_in   = ps;
    first     = f;
    last      = l;
    in_valid  = 1'b1;
    #2;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    model(x, w, ps, f, l);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_ov(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(tag, out_valid, 1);
  endtask

  task automatic hold_check(input string tag,
                            input logic [AW-1:0] ea,
                            input logic es);
    wait_ov({tag, "_ov"});
    chk({tag, "_acc"}, acc_out, ea);
    chk({tag, "_sat"}, sat_out, es);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sbq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    res_t r;
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("dup_out", out_valid, 0);
      end else begin
        r = sbq.pop_front();
        chk("sb_acc", acc_out, r.acc);
        chk("sb_sat", sat_out, r.sat);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    ifmap_in  = '0;
    filter_in = '0;
    psum_in   = '0;
    first     = 1'b0;
    last      = 1'b0;
    out_ready = 1'b0;
    m_acc     = '0;
    m_sat     = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc_out", acc_out, 0);
    chk("rst_sat_out", sat_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single first+last window, latency t+2
    send(3, -4, 100, 1, 1);
    @(negedge clk);
    #1 chk("lat_t1", out_valid, 0);
    @(negedge clk);
    #1 chk("lat_t2", out_valid, 1);
    hold_check("single", 88, 0);

    // three-beat window then a window without first
    send(2, 5, 0, 1, 0);
    send(7, 1, 0, 0, 0);
    send(-1, -1, 0, 0, 1);
    hold_check("win3", 18, 0);
    send(1, 1, 0, 0, 1);
    hold_check("nofirst", 1, 0);

    // saturation and sticky-flag clearing
    send(16'sh7FFF, 16'sh7FFF, 32'sh7FFF_FFF0, 1, 1);
    hold_check("sat", 32'h7FFF_FFFF, 1);
    send(1, 1, 0, 1, 1);
    hold_check("sat_clr", 1, 0);

    // backpressure with four beats waiting
    send(5, 6, 10, 1, 1);
    wait_ov("bp_ov");
    fork
      begin
        send(1, 2, 0, 1, 0);
        send(3, 4, 0, 0, 0);
        send(-5, 6, 0, 0, 0);
        send(7, -8, 0, 0, 1);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          #3;
          chk("bp_in_ready", in_ready, 0);
          chk("bp_hold", acc_out, 40);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // random streaming with zero gating
    @(posedge clk);
    rand_rdy = 1'b1;
    for (int k = 0; k < 64; k++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        logic signed [DW-1:0] x;
        x = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
        send(x, DW'($urandom), AW'($urandom), b == 0, b == len - 1);
        if ($urandom_range(0, 4) == 0) @(negedge clk);
      end
    end
    @(posedge clk);
    rand_rdy = 1'b0;
    drain("rand_drain");

    // reset in the middle of a window
    send(1, 1, 0, 1, 0);
    send(2, 2, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_acc_out", acc_out, 0);
    chk("mrst_in_ready", in_ready, 1);
    sbq.delete();
    m_acc = '0;
    m_sat = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    send(2, 2, 0, 1, 1);
    hold_check("post_rst", 4, 0);
    drain("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
